// File: rtl/uart_rx_fifo_if.sv
// Byte-receive and pop bus between uart_rx/consumer and uart_rx_fifo.
// master = producer + consumer side, slave = the FIFO.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DW-1:0] rx_data;
  logic          rx_ready;
  logic          rx_error;
  logic          rd_en;
  logic          clr_flags;
  logic [DW-1:0] rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          overflow;
  logic [7:0]    frame_err_cnt;

  modport master (
    output rx_data, rx_ready, rx_error, rd_en, clr_flags,
    input  rd_data, empty, full, count, overflow, frame_err_cnt
  );

  modport slave (
    input  rx_data, rx_ready, rx_error, rd_en, clr_flags,
    output rd_data, empty, full, count, overflow, frame_err_cnt
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// FWFT byte FIFO behind uart_rx: a write on each rx_ready rising edge, visible the next cycle.
// No backpressure to uart_rx: a good byte arriving while full (and no pop) is dropped and sets overflow.
module uart_rx_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  uart_rx_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_rdy_q;
  logic          r_overflow;
  logic [7:0]    r_frame_err_cnt;

  logic w_accept;
  logic w_bad;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == FULL_CNT);
  assign w_accept = bus.rx_ready & ~r_rdy_q;
  assign w_bad    = w_accept & bus.rx_error;
  assign w_pop    = bus.rd_en & ~w_empty;
  // A pop on the same edge frees the slot that a write into a full FIFO needs.
  assign w_push   = w_accept & ~bus.rx_error & (~w_full | w_pop);
  assign w_drop   = w_accept & ~bus.rx_error & w_full & ~w_pop;

  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_mem[r_wr_ptr] <= bus.rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_rdy_q  <= 1'b1;
    end else begin
      r_rdy_q <= bus.rx_ready;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Clear takes effect first, so an event on the clearing edge still registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow      <= 1'b0;
      r_frame_err_cnt <= '0;
    end else begin
      if (bus.clr_flags) begin
        r_overflow      <= w_drop;
        r_frame_err_cnt <= w_bad ? 8'd1 : 8'd0;
      end else begin
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
        if (w_bad && r_frame_err_cnt != 8'hFF) begin
          r_frame_err_cnt <= r_frame_err_cnt + 8'd1;
        end
      end
    end
  end

  assign bus.rd_data       = r_mem[r_rd_ptr];
  assign bus.empty         = w_empty;
  assign bus.full          = w_full;
  assign bus.count         = r_count;
  assign bus.overflow      = r_overflow;
  assign bus.frame_err_cnt = r_frame_err_cnt;
endmodule
